// File: rtl/in_port_ctrl.sv
// rtl/in_port_ctrl.sv - input-port byte FIFO with show-ahead CPU read and interrupt request
//
// Purpose:
//   Buffers bytes from an external source (valid/ready handshake) in a DEPTH-entry
//   FIFO, presents the head to the CPU IN datapath and pops it on cpu_rd. When
//   INPORT_IRQ_EN is defined, an interrupt FSM (IDLE -> FIRE -> WAIT -> GAP)
//   produces a one-cycle int_sig pulse while unread data is pending. When it is
//   undefined, int_sig is tied to 0, int_done is ignored and the CPU polls.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   ext_data   in   external byte
//   ext_valid  in   external byte present
//   ext_ready  out  FIFO can accept a byte
//   cpu_rd     in   one-cycle read strobe, pops the head
//   cpu_data   out  FIFO head, 0 when empty
//   cpu_empty  out  FIFO empty
//   fifo_count out  stored entries
//   int_done   in   one-cycle RTI pulse, ends service without a read
//   int_sig    out  interrupt request pulse
//
// Configuration macro: INPORT_IRQ_EN

module in_port_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ext_data,
    input  logic             ext_valid,
    output logic             ext_ready,
    input  logic             cpu_rd,
    output logic [WIDTH-1:0] cpu_data,
    output logic             cpu_empty,
    output logic [PTR_W:0]   fifo_count,
    input  logic             int_done,
    output logic             int_sig
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             rst_q;

    logic full;
    logic push;
    logic pop;

    // rst_q keeps ext_ready low for the cycle right after a reset edge.
    assign full       = (count_q == FULL_COUNT);
    assign ext_ready  = !full && !rst_q;
    assign cpu_empty  = (count_q == '0);
    assign fifo_count = count_q;
    assign push       = ext_valid && ext_ready;
    assign pop        = cpu_rd && !cpu_empty;

    // Show-ahead head; forced to 0 so stale storage never leaks when empty.
    assign cpu_data = cpu_empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= ext_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (count_q <= FULL_COUNT) && !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && count_q == '0));

`ifdef INPORT_IRQ_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } irq_state_e;

    irq_state_e state_q, state_d;
    logic       int_sig_q, int_sig_d;

    // int_sig is registered from the FIRE decode, so it lags FIRE by one
    // cycle: a push at edge N gives a pulse between edges N+2 and N+3.
    always_comb begin
        state_d   = state_q;
        int_sig_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cpu_empty) begin
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                int_sig_d = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (pop || int_done) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            int_sig_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            int_sig_q <= int_sig_d;
        end
    end

    assign int_sig = int_sig_q;
`else
    logic unused_int_done;
    assign unused_int_done = int_done;
    assign int_sig         = 1'b0;
`endif

endmodule

// File: tb/tb_in_port_ctrl.sv
// tb/tb_in_port_ctrl.sv - self-checking bench for in_port_ctrl

module tb_in_port_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

`ifdef INPORT_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] ext_data;
    logic             ext_valid;
    logic             ext_ready;
    logic             cpu_rd;
    logic [WIDTH-1:0] cpu_data;
    logic             cpu_empty;
    logic [PTR_W:0]   fifo_count;
    logic             int_done;
    logic             int_sig;

    int checks = 0;
    int errors = 0;

    in_port_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_data   (ext_data),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .cpu_rd     (cpu_rd),
        .cpu_data   (cpu_data),
        .cpu_empty  (cpu_empty),
        .fifo_count (fifo_count),
        .int_done   (int_done),
        .int_sig    (int_sig)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue, interrupt timing as edge
    // timestamps (when the next pending-data check may happen, when the pulse
    // is due, from which edge a service event is honoured).
    logic [WIDTH-1:0] mq[$];
    bit  m_valid   = 1'b0;
    bit  m_rstq    = 1'b1;
    bit  m_busy    = 1'b0;
    int  edge_cnt  = 0;
    int  m_last    = 0;
    int  m_check   = 0;
    int  m_pulse   = -1;
    int  m_serv    = 0;
    bit  m_pop;
    bit  m_push;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_rstq  = 1'b1;
            m_busy  = 1'b0;
            m_check = edge_cnt + 1;
            m_pulse = -1;
        end else begin
            m_pop  = cpu_rd && (mq.size() != 0);
            m_push = ext_valid && !m_rstq && (mq.size() < DEPTH);
            if (IRQ_EN) begin
                if (!m_busy && edge_cnt >= m_check && mq.size() != 0) begin
                    m_busy  = 1'b1;
                    m_pulse = edge_cnt + 1;
                    m_serv  = edge_cnt + 2;
                end else if (m_busy && edge_cnt >= m_serv && (m_pop || int_done)) begin
                    m_busy  = 1'b0;
                    m_check = edge_cnt + 2;
                end
            end
            if (m_pop) begin
                void'(mq.pop_front());
            end
            if (m_push) begin
                mq.push_back(ext_data);
            end
            m_rstq = 1'b0;
        end
        m_last = edge_cnt;
        edge_cnt++;
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_count", 32'(fifo_count), 32'(mq.size()));
            check("m_empty", 32'(cpu_empty), 32'(mq.size() == 0));
            check("m_ready", 32'(ext_ready), 32'(!m_rstq && mq.size() < DEPTH));
            check("m_data", 32'(cpu_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
            check("m_int", 32'(int_sig), 32'(IRQ_EN && (m_last == m_pulse)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        ext_valid = 1'b1;
        ext_data  = 8'h77;
        cpu_rd    = 1'b0;
        int_done  = 1'b0;

        // Reset held 2 cycles with ext_valid high
        step();
        step();
        check("rst_ready", 32'(ext_ready), 32'h0);
        check("rst_empty", 32'(cpu_empty), 32'h1);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_data", 32'(cpu_data), 32'h0);
        rst       = 1'b0;
        ext_valid = 1'b0;
        step();
        check("rel_ready", 32'(ext_ready), 32'h1);
        check("rel_count", 32'(fifo_count), 32'h0);

        // Single byte
        ext_data  = 8'h26;
        ext_valid = 1'b1;
        step();
        ext_valid = 1'b0;
        check("sb_data", 32'(cpu_data), 32'h26);
        check("sb_count", 32'(fifo_count), 32'h1);
        check("sb_int_n0", 32'(int_sig), 32'h0);
        step();
        check("sb_int_n1", 32'(int_sig), 32'h0);
        step();
        check("sb_int_n2", 32'(int_sig), 32'(IRQ_EN));
        step();
        check("sb_int_n3", 32'(int_sig), 32'h0);
        cpu_rd = 1'b1;
        check("sb_rd_data", 32'(cpu_data), 32'h26);
        step();
        cpu_rd = 1'b0;
        check("sb_empty", 32'(cpu_empty), 32'h1);
        step();
        step();

        // Fill and wrap
        for (int i = 1; i <= 4; i++) begin
            ext_data  = 8'(i);
            ext_valid = 1'b1;
            step();
        end
        ext_data = 8'h05;
        check("fill_ready", 32'(ext_ready), 32'h0);
        check("fill_count", 32'(fifo_count), 32'h4);
        cpu_rd = 1'b1;
        check("fill_pop1", 32'(cpu_data), 32'h01);
        step();
        cpu_rd = 1'b0;
        check("fill_cnt3", 32'(fifo_count), 32'h3);
        check("fill_ready2", 32'(ext_ready), 32'h1);
        step();
        ext_valid = 1'b0;
        check("fill_cnt4", 32'(fifo_count), 32'h4);
        for (int v = 2; v <= 5; v++) begin
            cpu_rd = 1'b1;
            check("fill_popv", 32'(cpu_data), 32'(v));
            step();
        end
        cpu_rd = 1'b0;
        check("fill_drained", 32'(cpu_empty), 32'h1);
        for (int i = 0; i < 4; i++) step();

        // Simultaneous push and pop at count 2
        ext_valid = 1'b1;
        ext_data  = 8'h10;
        step();
        ext_data  = 8'h11;
        step();
        ext_data  = 8'hAA;
        cpu_rd    = 1'b1;
        check("sim_head", 32'(cpu_data), 32'h10);
        step();
        ext_valid = 1'b0;
        check("sim_count", 32'(fifo_count), 32'h2);
        check("sim_head2", 32'(cpu_data), 32'h11);
        step();
        check("sim_head3", 32'(cpu_data), 32'hAA);
        step();
        cpu_rd = 1'b0;
        check("sim_empty", 32'(cpu_empty), 32'h1);
        for (int i = 0; i < 4; i++) step();

        // Service via int_done with data left
        ext_valid = 1'b1;
        ext_data  = 8'h31;
        step();
        ext_data  = 8'h32;
        step();
        ext_valid = 1'b0;
        check("id_int0", 32'(int_sig), 32'h0);
        step();
        check("id_int1", 32'(int_sig), 32'(IRQ_EN));
        step();
        int_done = 1'b1;
        step();
        int_done = 1'b0;
        check("id_m0", 32'(int_sig), 32'h0);
        step();
        check("id_m1", 32'(int_sig), 32'h0);
        step();
        check("id_m2", 32'(int_sig), 32'h0);
        step();
        check("id_m3", 32'(int_sig), 32'(IRQ_EN));
        check("id_count", 32'(fifo_count), 32'h2);
        cpu_rd = 1'b1;
        check("id_pop1", 32'(cpu_data), 32'h31);
        step();
        check("id_pop2", 32'(cpu_data), 32'h32);
        step();
        cpu_rd = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Empty read
        cpu_rd = 1'b1;
        check("er_data", 32'(cpu_data), 32'h0);
        step();
        cpu_rd = 1'b0;
        check("er_count", 32'(fifo_count), 32'h0);
        check("er_empty", 32'(cpu_empty), 32'h1);

        // Mid-operation reset in WAIT with 3 bytes stored
        ext_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ext_data = 8'(8'h40 + i);
            step();
        end
        ext_valid = 1'b0;
        step();
        step();
        check("mr_count3", 32'(fifo_count), 32'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_count0", 32'(fifo_count), 32'h0);
        check("mr_empty", 32'(cpu_empty), 32'h1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("mr_int", 32'(int_sig), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
